display_bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-decimal seven-segment driver for the board's HEX displays. It accepts an unsigned binary value on a start strobe and converts it to BCD with a multi-cycle shift-add-3 (double-dabble) engine. It then drives one seven-segment pattern per decimal digit, with optional leading-zero blanking and selectable segment polarity. It sits between datapath results and the HEX pins, replacing per-nibble combinational decoding where values exceed one digit.

---
 rtl/display_pkg.sv | 39 +++
 rtl/seg7_decoder.sv | 32 +++
 rtl/display_bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_display_bin2bcd_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the HEX display drivers.
// Glyphs are active-high with bit 0 = segment a through bit 6 = segment g.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // 10^n for elaboration-time range checks.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit code to active-high seven-segment glyph (0-F).
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Glyph lookup for every hex code.
  always_comb begin
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_bin2bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter driving one seven-segment
// pattern per decimal digit, with leading-zero blanking and selectable polarity.
module display_bin2bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DIGITS        = 3,
  parameter int ACTIVE_LOW    = 1,
  parameter int BLANK_LEADING = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      number,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int         CW      = $clog2(WIDTH + 1);
  localparam int         BW      = 4 * DIGITS;
  localparam logic [6:0] POL     = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [6:0] SEG_OFF = SEG_BLANK ^ POL;

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("display_bin2bcd_seq: WIDTH must be within 4..32");
  end
  if (DIGITS < 1 || DIGITS > 19 ||
      pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $error("display_bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_t                    state_r;
  logic [WIDTH-1:0]          bin_r;
  logic [BW-1:0]             scratch_r;
  logic [CW-1:0]             cnt_r;
  logic [BW-1:0]             adj_s;
  logic [DIGITS-1:0][6:0]    glyph_s;
  logic [7*DIGITS-1:0]       hex_next_s;

  // Add-3 correction on every scratch digit that is 5 or more.
  always_comb begin
    adj_s = '0;
    for (int d = 0; d < DIGITS; d++) begin
      adj_s[4*d +: 4] = (scratch_r[4*d +: 4] >= 4'd5) ? scratch_r[4*d +: 4] + 4'd3
                                                       : scratch_r[4*d +: 4];
    end
  end

  for (genvar d = 0; d < DIGITS; d++) begin : g_dec
    seg7_decoder u_dec (
      .code (scratch_r[4*d +: 4]),
      .seg  (glyph_s[d])
    );
  end

  // Blank from the top down while digits stay zero; digit 0 always shows.
  always_comb begin
    logic upper_zero;
    upper_zero = (BLANK_LEADING != 0);
    hex_next_s = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      upper_zero = upper_zero && (scratch_r[4*d +: 4] == 4'd0) && (d != 0);
      hex_next_s[7*d +: 7] = (upper_zero ? SEG_BLANK : glyph_s[d]) ^ POL;
    end
  end

  // Conversion FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bin_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      hex       <= {DIGITS{SEG_OFF}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            bin_r     <= number;
            scratch_r <= '0;
            cnt_r     <= '0;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          scratch_r <= {adj_s[BW-2:0], bin_r[WIDTH-1]};
          bin_r     <= {bin_r[WIDTH-2:0], 1'b0};
          cnt_r     <= cnt_r + CW'(1);
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r <= LOAD;
          end else begin
            state_r <= SHIFT;
          end
        end
        LOAD: begin
          bcd     <= scratch_r;
          hex     <= hex_next_s;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_bin2bcd_seq.sv
// Directed self-checking bench for display_bin2bcd_seq (WIDTH=8, DIGITS=3).
module tb_display_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_h;
  logic [7:0]  number, number_h;
  logic        busy, done, busy_h, done_h;
  logic [11:0] bcd, bcd_h;
  logic [20:0] hex, hex_h;

  int checks = 0;
  int errors = 0;

  logic [6:0] al_tab [10];

  always #5 clk = ~clk;

  display_bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(1), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .number(number),
    .busy(busy), .done(done), .bcd(bcd), .hex(hex)
  );

  display_bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .ACTIVE_LOW(0), .BLANK_LEADING(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(start_h), .number(number_h),
    .busy(busy_h), .done(done_h), .bcd(bcd_h), .hex(hex_h)
  );

  // Pulse start for one cycle; lat = edges after the accepting edge until done (-1 on timeout).
  task automatic convert(input logic [7:0] val, output int lat, output logic busy_ok);
    number  = val;
    start   = 1'b1;
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = i - 1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_h = 1'b0; number = 8'd0; number_h = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd got %h want 000", bcd); end
    checks++; if (hex !== 21'h1FFFFF) begin errors++; $display("FAIL reset_hex got %h want 1fffff", hex); end
    checks++; if (hex_h !== 21'h000000) begin errors++; $display("FAIL reset_hex_ah got %h want 0", hex_h); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_255();
    int lat; logic bok;
    convert(8'd255, lat, bok);
    checks++; if (lat != 9) begin errors++; $display("FAIL lat255 got %0d want 9", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL busy255 got low during conversion want high"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", busy); end
    checks++; if (bcd !== 12'h255) begin errors++; $display("FAIL bcd255 got %h want 255", bcd); end
    checks++; if (hex !== {7'h24, 7'h12, 7'h12}) begin
      errors++; $display("FAIL hex255 got %h want %h", hex, {7'h24, 7'h12, 7'h12});
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_blanking();
    int lat; logic bok;
    convert(8'd0, lat, bok);
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL bcd0 got %h want 000", bcd); end
    checks++; if (hex !== {7'h7F, 7'h7F, 7'h40}) begin
      errors++; $display("FAIL hex0 got %h want %h", hex, {7'h7F, 7'h7F, 7'h40});
    end
    convert(8'd7, lat, bok);
    checks++; if (bcd !== 12'h007) begin errors++; $display("FAIL bcd7 got %h want 007", bcd); end
    checks++; if (hex !== {7'h7F, 7'h7F, 7'h78}) begin
      errors++; $display("FAIL hex7 got %h want %h", hex, {7'h7F, 7'h7F, 7'h78});
    end
    convert(8'd105, lat, bok);
    checks++; if (bcd !== 12'h105) begin errors++; $display("FAIL bcd105 got %h want 105", bcd); end
    checks++; if (hex !== {7'h79, 7'h40, 7'h12}) begin
      errors++; $display("FAIL hex105 got %h want %h", hex, {7'h79, 7'h40, 7'h12});
    end
  endtask

  task automatic test_back_to_back();
    int          done_at [$];
    logic [11:0] bcd_at  [$];
    number = 8'd18;
    start  = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      if (done) begin
        done_at.push_back(i);
        bcd_at.push_back(bcd);
      end
      if (i == 3)  number = 8'd200;
      if (i == 13) number = 8'd55;
      if (i == 21) start  = 1'b0;
      if (i == 23) number = 8'd99;
    end
    checks++; if (done_at.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", done_at.size());
    end else begin
      checks++; if (done_at[0] != 10 || done_at[1] != 20 || done_at[2] != 30) begin
        errors++; $display("FAIL b2b_timing got %0d,%0d,%0d want 10,20,30", done_at[0], done_at[1], done_at[2]);
      end
      checks++; if (bcd_at[0] !== 12'h018) begin errors++; $display("FAIL b2b_bcd0 got %h want 018", bcd_at[0]); end
      checks++; if (bcd_at[1] !== 12'h200) begin errors++; $display("FAIL b2b_bcd1 got %h want 200", bcd_at[1]); end
      checks++; if (bcd_at[2] !== 12'h055) begin errors++; $display("FAIL b2b_bcd2 got %h want 055", bcd_at[2]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic bok; int pulses;
    number = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (bcd !== 12'h000) begin errors++; $display("FAIL abort_bcd got %h want 000", bcd); end
    checks++; if (hex !== 21'h1FFFFF) begin errors++; $display("FAIL abort_hex got %h want 1fffff", hex); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", pulses); end
    convert(8'd200, lat, bok);
    checks++; if (lat != 9) begin errors++; $display("FAIL abort_relat got %0d want 9", lat); end
    checks++; if (bcd !== 12'h200) begin errors++; $display("FAIL abort_rebcd got %h want 200", bcd); end
    checks++; if (hex !== {7'h24, 7'h40, 7'h40}) begin
      errors++; $display("FAIL abort_rehex got %h want %h", hex, {7'h24, 7'h40, 7'h40});
    end
  endtask

  task automatic test_sweep_active_high();
    logic [7:0]  v;
    logic [3:0]  h, t, o;
    logic [11:0] exp_bcd;
    logic [20:0] exp_hex;
    int          lat;
    for (int i = 0; i < 256; i++) begin
      v = 8'((i * 37 + 11) & 255);
      h = 4'(v / 100);
      t = 4'((v / 10) % 10);
      o = 4'(v % 10);
      exp_bcd = {h, t, o};
      exp_hex = ~{al_tab[h], al_tab[t], al_tab[o]};
      number_h = v;
      start_h  = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        start_h = 1'b0;
        if (done_h) begin
          lat = c - 1;
          break;
        end
      end
      checks++; if (lat != 9) begin errors++; $display("FAIL sweep_lat v=%0d got %0d want 9", v, lat); end
      checks++; if (bcd_h !== exp_bcd) begin errors++; $display("FAIL sweep_bcd v=%0d got %h want %h", v, bcd_h, exp_bcd); end
      checks++; if (hex_h !== exp_hex) begin errors++; $display("FAIL sweep_hex v=%0d got %h want %h", v, hex_h, exp_hex); end
    end
  endtask

  initial begin
    al_tab[0] = 7'h40; al_tab[1] = 7'h79; al_tab[2] = 7'h24; al_tab[3] = 7'h30; al_tab[4] = 7'h19;
    al_tab[5] = 7'h12; al_tab[6] = 7'h02; al_tab[7] = 7'h78; al_tab[8] = 7'h00; al_tab[9] = 7'h10;
    test_reset();
    test_255();
    test_blanking();
    test_back_to_back();
    test_reset_abort();
    test_sweep_active_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
